panda_data_bus_adapter: RTL and testbench

PANDA_DATA_BUS_ADAPTER -- requirements
Module: panda_data_bus_adapter

---
 rtl/panda_pkg.sv | 19 +
 rtl/panda_data_bus_adapter.sv | 125 ++++++++++++
 tb/tb_panda_data_bus_adapter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/panda_pkg.sv
// Shared types and helpers for the panda data-bus adapter.
// Holds the adapter FSM state type and the byte-enable rule for loads versus stores.
package panda_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } dbus_state_e;

  localparam logic [3:0] BeAll = 4'b1111;

  // Loads read the whole word; stores use the core's byte enables unchanged.
  function automatic logic [3:0] bus_be_for(input logic [3:0] we);
    return (we == 4'b0000) ? BeAll : we;
  endfunction

endpackage

// File: rtl/panda_data_bus_adapter.sv
// Bridges the core load/store unit to a req/gnt + rvalid data bus.
// One access in flight; the core is stalled from request until the response completes.
module panda_data_bus_adapter
  import panda_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        lsu_req_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_we_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        lsu_stall_o,

  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  localparam int unsigned CntW      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES);
  localparam bit TimeoutEn          = (TIMEOUT_CYCLES != 0);

  dbus_state_e     state_q, state_d;
  logic [29:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      we_q, we_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    lsu_stall_o = 1'b0;
    bus_req_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (lsu_req_i) begin
          lsu_stall_o = 1'b1;
          addr_d      = lsu_addr_i[31:2];
          wdata_d     = lsu_wdata_i;
          we_d        = lsu_we_i;
          cnt_d       = '0;
          state_d     = StReq;
        end
      end
      StReq: begin
        lsu_stall_o = 1'b1;
        bus_req_o   = 1'b1;
        // A grant on the final allowed cycle takes priority over the abort.
        if (bus_gnt_i) begin
          state_d = StWait;
        end else if (TimeoutEn && (cnt_inc == CntLimit)) begin
          cnt_d   = cnt_inc;
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else if (TimeoutEn) begin
          cnt_d = cnt_inc;
        end
      end
      StWait: begin
        lsu_stall_o = 1'b1;
        if (bus_rvalid_i) begin
          rdata_d = bus_rdata_i;
          err_d   = bus_err_i;
          state_d = StDone;
        end
      end
      StDone: begin
        // Any lsu_req_i seen here still belongs to the access now completing.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus_addr_o  = {addr_q, 2'b00};
  assign bus_wdata_o = wdata_q;
  assign bus_we_o    = |we_q;
  assign bus_be_o    = bus_be_for(we_q);
  assign lsu_rdata_o = rdata_q;
  assign lsu_err_o   = err_q;

endmodule

// File: tb/tb_panda_data_bus_adapter.sv
// Self-checking bench: directed vector table, randomized accesses against a
// spec-level model, plus reset-abandon and timeout sequences.
module tb_panda_data_bus_adapter;

  logic        clk;
  logic        rst;
  logic        lsu_req;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_we;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        lsu_stall;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  // Second instance with a short timeout
  logic        t_lsu_req;
  logic        t_gnt;
  logic [31:0] t_lsu_rdata;
  logic        t_lsu_err;
  logic        t_lsu_stall;
  logic        t_bus_req;
  logic [31:0] t_bus_addr;
  logic [31:0] t_bus_wdata;
  logic        t_bus_we;
  logic [3:0]  t_bus_be;

  int checks = 0;
  int errors = 0;

  panda_data_bus_adapter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .lsu_req_i   (lsu_req),
    .lsu_addr_i  (lsu_addr),
    .lsu_wdata_i (lsu_wdata),
    .lsu_we_i    (lsu_we),
    .lsu_rdata_o (lsu_rdata),
    .lsu_err_o   (lsu_err),
    .lsu_stall_o (lsu_stall),
    .bus_req_o   (bus_req),
    .bus_gnt_i   (bus_gnt),
    .bus_addr_o  (bus_addr),
    .bus_wdata_o (bus_wdata),
    .bus_we_o    (bus_we),
    .bus_be_o    (bus_be),
    .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i (bus_rdata),
    .bus_err_i   (bus_err)
  );

  panda_data_bus_adapter #(
    .TIMEOUT_CYCLES(4)
  ) dut_to (
    .clk_i       (clk),
    .rst_i       (rst),
    .lsu_req_i   (t_lsu_req),
    .lsu_addr_i  (lsu_addr),
    .lsu_wdata_i (lsu_wdata),
    .lsu_we_i    (lsu_we),
    .lsu_rdata_o (t_lsu_rdata),
    .lsu_err_o   (t_lsu_err),
    .lsu_stall_o (t_lsu_stall),
    .bus_req_o   (t_bus_req),
    .bus_gnt_i   (t_gnt),
    .bus_addr_o  (t_bus_addr),
    .bus_wdata_o (t_bus_wdata),
    .bus_we_o    (t_bus_we),
    .bus_be_o    (t_bus_be),
    .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i (bus_rdata),
    .bus_err_i   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    int          gd;
    int          rd;
    logic [31:0] rdat;
    logic        rerr;
    logic        junk;
    logic        hold;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: word-aligned address, full-word enables for loads.
  function automatic logic [31:0] model_addr(input logic [31:0] a);
    return a - (a % 32'd4);
  endfunction

  function automatic logic [3:0] model_be(input logic [3:0] we);
    return (we == 4'd0) ? 4'hF : we;
  endfunction

  // One access: IDLE cycle, gd+1 REQ cycles (grant on last), rd+1 WAIT cycles
  // (rvalid on last), then DONE.
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] we, input int gd, input int rd,
                           input logic [31:0] rdat, input logic rerr, input logic junk,
                           input logic hold, input logic [31:0] e_addr,
                           input logic [3:0] e_be, input logic e_we);
    @(negedge clk);
    chk("idle_bus_req", 32'(bus_req), 32'd0);
    lsu_req   = 1'b1;
    lsu_addr  = addr;
    lsu_wdata = wdata;
    lsu_we    = we;
    #1;
    chk("idle_stall", 32'(lsu_stall), 32'd1);
    for (int c = 0; c <= gd; c++) begin
      @(negedge clk);
      bus_gnt    = (c == gd);
      bus_rvalid = junk;
      bus_rdata  = ~rdat;
      bus_err    = junk;
      #1;
      chk("req_bus_req", 32'(bus_req), 32'd1);
      chk("req_stall", 32'(lsu_stall), 32'd1);
      chk("req_addr", bus_addr, e_addr);
      chk("req_be", 32'(bus_be), 32'(e_be));
      chk("req_we", 32'(bus_we), 32'(e_we));
      chk("req_wdata", bus_wdata, wdata);
    end
    for (int c = 0; c <= rd; c++) begin
      @(negedge clk);
      bus_gnt    = 1'b0;
      bus_rvalid = (c == rd);
      bus_rdata  = (c == rd) ? rdat : $urandom;
      bus_err    = (c == rd) ? rerr : 1'b0;
      #1;
      chk("wait_bus_req", 32'(bus_req), 32'd0);
      chk("wait_stall", 32'(lsu_stall), 32'd1);
    end
    @(negedge clk);
    bus_rvalid = 1'b0;
    bus_err    = 1'b0;
    lsu_req    = hold;
    #1;
    chk("done_stall", 32'(lsu_stall), 32'd0);
    chk("done_rdata", lsu_rdata, rdat);
    chk("done_err", 32'(lsu_err), 32'(rerr));
    chk("done_bus_req", 32'(bus_req), 32'd0);
  endtask

  // Access on the short-timeout instance: n REQ cycles, grant on the last if granted.
  task automatic t_run(input int n, input logic grant, input logic [31:0] rdat);
    @(negedge clk);
    chk("t_idle_bus_req", 32'(t_bus_req), 32'd0);
    t_lsu_req = 1'b1;
    lsu_addr  = 32'h0000_7004;
    lsu_we    = 4'h0;
    #1;
    chk("t_idle_stall", 32'(t_lsu_stall), 32'd1);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      t_gnt = grant && (c == n - 1);
      #1;
      chk("t_req_bus_req", 32'(t_bus_req), 32'd1);
    end
    if (grant) begin
      @(negedge clk);
      t_gnt      = 1'b0;
      bus_rvalid = 1'b1;
      bus_rdata  = rdat;
      bus_err    = 1'b0;
      #1;
      chk("t_wait_stall", 32'(t_lsu_stall), 32'd1);
    end
    @(negedge clk);
    t_gnt      = 1'b0;
    bus_rvalid = 1'b0;
    t_lsu_req  = 1'b0;
    #1;
    chk("t_done_bus_req", 32'(t_bus_req), 32'd0);
    chk("t_done_stall", 32'(t_lsu_stall), 32'd0);
    chk("t_done_err", 32'(t_lsu_err), grant ? 32'd0 : 32'd1);
    chk("t_done_rdata", t_lsu_rdata, grant ? rdat : 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_1006, 32'h0, 4'h0, 0, 0, 32'hA5A5_1234, 1'b0, 1'b0, 1'b0,
                32'h0000_1004, 4'hF, 1'b0};
    vecs[1] = '{32'h0000_2000, 32'hBEEF_BEEF, 4'hC, 5, 1, 32'h1234_5678, 1'b0, 1'b0, 1'b0,
                32'h0000_2000, 4'hC, 1'b1};
    vecs[2] = '{32'h0000_3003, 32'h0, 4'h0, 2, 0, 32'h0BAD_0BAD, 1'b1, 1'b1, 1'b0,
                32'h0000_3000, 4'hF, 1'b0};
    vecs[3] = '{32'h0000_4001, 32'h1111_1111, 4'h1, 0, 1, 32'h2222_2222, 1'b0, 1'b0, 1'b1,
                32'h0000_4000, 4'h1, 1'b1};
    vecs[4] = '{32'h0000_5002, 32'h0, 4'h0, 1, 2, 32'h3333_3333, 1'b0, 1'b0, 1'b1,
                32'h0000_5000, 4'hF, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0, 4'h0, 1, 0, 32'h4444_4444, 1'b0, 1'b0, 1'b0,
                32'hFFFF_FFFC, 4'hF, 1'b0};

    rst        = 1'b1;
    lsu_req    = 1'b0;
    lsu_addr   = '0;
    lsu_wdata  = '0;
    lsu_we     = '0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    bus_err    = 1'b0;
    t_lsu_req  = 1'b0;
    t_gnt      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(lsu_stall), 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_err", 32'(lsu_err), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_t_bus_req", 32'(t_bus_req), 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_access(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].gd, vecs[i].rd,
                vecs[i].rdat, vecs[i].rerr, vecs[i].junk, vecs[i].hold,
                vecs[i].e_addr, vecs[i].e_be, vecs[i].e_we);
    end

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  we;
      a  = $urandom;
      wd = $urandom;
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      do_access(a, wd, we, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                model_addr(a), model_be(we), we != 4'h0);
    end

    // Reset while waiting for the response; a late rvalid must be dropped.
    do_access(32'h0000_6100, 32'h0, 4'h0, 0, 0, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0,
              32'h0000_6100, 4'hF, 1'b0);
    @(negedge clk);
    lsu_req  = 1'b1;
    lsu_addr = 32'h0000_6000;
    lsu_we   = 4'h0;
    @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    rst     = 1'b1;
    #1;
    chk("rstwait_stall", 32'(lsu_stall), 32'd1);
    @(negedge clk);
    rst        = 1'b0;
    lsu_req    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h7777_7777;
    #1;
    chk("rstwait_bus_req", 32'(bus_req), 32'd0);
    chk("rstwait_stall_after", 32'(lsu_stall), 32'd0);
    chk("rstwait_rdata", lsu_rdata, 32'd0);
    chk("rstwait_err", 32'(lsu_err), 32'd0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    chk("rstwait_ignored_rdata", lsu_rdata, 32'd0);
    chk("rstwait_ignored_stall", 32'(lsu_stall), 32'd0);
    chk("rstwait_ignored_bus_req", 32'(bus_req), 32'd0);

    // Short-timeout instance: normal load, abort, then grant on the boundary cycle.
    t_run(1, 1'b1, 32'hDEAD_BEEF);
    t_run(4, 1'b0, 32'h0);
    t_run(4, 1'b1, 32'h1357_2468);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
